ram_stream_loader: RTL
======================

RAM_STREAM_LOADER -- requirements
Module: ram_stream_loader

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the RAM address width (4096 locations).
REQ-002 Parameter DATA_W, default 8, SHALL set the pixel/byte width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 start_load  in  1  SHALL request a stream-to-RAM write burst (sampled in IDLE only).
REQ-006 start_dump  in  1  SHALL request a RAM-to-stream read burst (sampled in IDLE only).
REQ-007 base_addr  in  ADDR_W  SHALL give the first RAM address of the burst, latched at start.
REQ-008 length  in  ADDR_W+1  SHALL give the burst byte count (0..4096), latched at start.
REQ-009 s_data  in  DATA_W, s_valid  in  1, s_ready  out  1  SHALL form the input byte stream handshake.
REQ-010 m_data  out  DATA_W, m_valid  out  1, m_ready  in  1  SHALL form the output byte stream handshake.
REQ-011 ram_w_en  out  1, ram_r_en  out  1, ram_address  out  ADDR_W, ram_data_in  out  DATA_W  SHALL drive the RAM port.
REQ-012 ram_data_out  in  DATA_W  SHALL carry RAM read data, valid the cycle after ram_r_en.
REQ-013 busy  out  1  SHALL be high in every state except IDLE.
REQ-014 done  out  1  SHALL pulse high for exactly one cycle at burst end.
REQ-015 count  out  ADDR_W+1  SHALL report bytes transferred in the current/last burst.

Function
REQ-016 States SHALL be IDLE, LOAD, RD_REQ, RD_CAP, RD_OUT, DONE.
REQ-017 IDLE: start_load -> LOAD; start_dump -> RD_REQ; both high -> LOAD wins; count cleared to 0 on any accepted start.
REQ-018 Accepted start with length==0 SHALL go directly to DONE with no RAM access and no handshake.
REQ-019 Start inputs outside IDLE SHALL be ignored.
REQ-020 LOAD: s_ready=1; on s_valid&&s_ready, same cycle ram_w_en=1, ram_address=base+count, ram_data_in=s_data (combinational), count increments at edge.
REQ-021 LOAD SHALL go to DONE on the edge accepting the length-th byte; s_ready=0 in DONE.
REQ-022 RD_REQ: ram_r_en=1, ram_address=base+count for one cycle -> RD_CAP.
REQ-023 RD_CAP: m_data registered from ram_data_out at end of cycle -> RD_OUT.
REQ-024 RD_OUT: m_valid=1, m_data stable until m_ready; on m_valid&&m_ready count increments, then DONE if count+1==length else RD_REQ.
REQ-025 Throughput SHALL be 1 byte/cycle in LOAD and 1 byte per 3 cycles (m_ready held high) in dump.
REQ-026 Address arithmetic SHALL wrap modulo 2^ADDR_W (base 4095, next 0).
REQ-027 DONE: done=1 for one cycle, then IDLE; count holds its final value until next start.
REQ-028 ram_w_en SHALL be 0 outside LOAD; ram_r_en SHALL be 0 outside RD_REQ; never both high.
REQ-029 s_ready, m_valid SHALL be 0 in all states other than LOAD and RD_OUT respectively.

Reset
REQ-030 rst=1 SHALL force IDLE at the next edge; count=0, m_data=0, m_valid=0, done=0, busy=0.
REQ-031 While rst=1, ram_w_en, ram_r_en, s_ready SHALL be 0 combinationally regardless of state.
REQ-032 Reset mid-burst SHALL abandon the burst without done; bytes already written remain in RAM.

Verification
REQ-033 Load base=0x010, length=4, bytes A0..A3 back-to-back -> writes 0x010..0x013 on 4 consecutive cycles, done one cycle later, count=4.
REQ-034 Dump base=0x010, length=4, m_ready=1 -> m_data A0,A1,A2,A3, one beat every 3 cycles, done after last, count=4.
REQ-035 Dump with m_ready low 5 cycles on 2nd beat -> m_valid and m_data held stable, no extra RAM reads, order preserved.
REQ-036 Load base=0xFFE, length=3 -> writes to 0xFFE, 0xFFF, 0x000.
REQ-037 start_load and start_dump same cycle, length=0 -> done next cycle, no ram_w_en/ram_r_en, count=0.
REQ-038 rst asserted after 2 of 5 load bytes -> IDLE, busy=0, no done, RAM 0..1 written, later load restarts at count 0.

Source files
------------

// File: rtl/ram_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ram_stream_loader
//  Description : Moves byte bursts between a valid/ready stream and a
//                single-port synchronous RAM. A load burst writes incoming
//                stream bytes to consecutive RAM addresses; a dump burst
//                reads consecutive RAM addresses out onto a stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_stream_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  // burst control
  input  logic              start_load,
  input  logic              start_dump,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  // input byte stream
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  // output byte stream
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  // RAM port
  output logic              ram_w_en,
  output logic              ram_r_en,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  // status
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RD_REQ = 3'd2;
  localparam logic [2:0] S_RD_CAP = 3'd3;
  localparam logic [2:0] S_RD_OUT = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [ADDR_W:0] C_ZERO = '0;
  localparam logic [ADDR_W:0] C_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [2:0]        state_q,  state_d;
  logic [ADDR_W-1:0] base_q,   base_d;
  logic [ADDR_W:0]   len_q,    len_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;

  logic              w_start;
  logic              w_in_beat;
  logic              w_out_beat;
  logic              w_last;
  logic [ADDR_W:0]   w_count_inc;
  logic [ADDR_W-1:0] w_addr;

  // Either start request counts as a start; load has priority in the FSM.
  assign w_start     = start_load | start_dump;
  assign w_count_inc = count_q + C_ONE;
  // The beat being transferred now is the final one of the burst.
  assign w_last      = (w_count_inc == len_q);
  // Address wraps naturally because only the low ADDR_W bits of count are added.
  assign w_addr      = base_q + count_q[ADDR_W-1:0];
  // Reset gates the input handshake so nothing is written while rst is high.
  assign w_in_beat   = (state_q == S_LOAD) && s_valid && !rst;
  assign w_out_beat  = (state_q == S_RD_OUT) && m_ready;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      count_q  <= '0;
      m_data_q <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      count_q  <= count_d;
      m_data_q <= m_data_d;
    end
  end

  // Next-state logic for the burst sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_start) begin
          if (length == C_ZERO) begin
            state_d = S_DONE;
          end else if (start_load) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end
      S_LOAD: begin
        if (w_in_beat && w_last) begin
          state_d = S_DONE;
        end
      end
      S_RD_REQ: state_d = S_RD_CAP;
      S_RD_CAP: state_d = S_RD_OUT;
      S_RD_OUT: begin
        if (w_out_beat) begin
          state_d = w_last ? S_DONE : S_RD_REQ;
        end
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Burst parameters, byte counter and captured read data.
  always_comb begin
    base_d   = base_q;
    len_d    = len_q;
    count_d  = count_q;
    m_data_d = m_data_q;
    case (state_q)
      S_IDLE: begin
        if (w_start) begin
          base_d  = base_addr;
          len_d   = length;
          count_d = C_ZERO;
        end
      end
      S_LOAD: begin
        if (w_in_beat) begin
          count_d = w_count_inc;
        end
      end
      S_RD_CAP: m_data_d = ram_data_out;
      S_RD_OUT: begin
        if (w_out_beat) begin
          count_d = w_count_inc;
        end
      end
      default: ;
    endcase
  end

  // Handshake, RAM strobes and status decoded from the current state.
  always_comb begin
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    ram_w_en    = 1'b0;
    ram_r_en    = 1'b0;
    ram_address = '0;
    ram_data_in = '0;
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    case (state_q)
      S_LOAD: begin
        s_ready     = !rst;
        ram_w_en    = w_in_beat;
        ram_address = w_addr;
        ram_data_in = s_data;
      end
      S_RD_REQ: begin
        ram_r_en    = !rst;
        ram_address = w_addr;
      end
      S_RD_OUT: m_valid = 1'b1;
      default: ;
    endcase
  end

  assign m_data = m_data_q;
  assign count  = count_q;

endmodule
`default_nettype wire
